// File: rtl/d_en_shreg_if.sv
// d_en_shreg_if -- bundle of control, data and status signals for d_en_shreg.
//   master : drives en, mode, d, sin, start; observes q, qn, sout, busy, done
//   slave  : the register itself (inputs/outputs mirrored)
// WIDTH must match the WIDTH of the d_en_shreg instance it is connected to.
interface d_en_shreg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;     // clock enable
  logic [2:0]       mode;   // idle-time operation select
  logic [WIDTH-1:0] d;      // parallel data
  logic             sin;    // serial input
  logic             start;  // begin serialization of d
  logic [WIDTH-1:0] q;      // register contents
  logic [WIDTH-1:0] qn;     // ~q
  logic             sout;   // q[0]
  logic             busy;   // serializer active
  logic             done;   // one-cycle completion pulse

  modport master (
    output en, mode, d, sin, start,
    input  q, qn, sout, busy, done
  );

  modport slave (
    input  en, mode, d, sin, start,
    output q, qn, sout, busy, done
  );
endinterface

// File: rtl/d_en_shreg.sv
// d_en_shreg -- WIDTH-bit enabled register with load/shift/rotate/clear/set
// modes and an autonomous LSB-first serializer.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (q <= RESET_VAL, FSM to IDLE)
//   bus  : d_en_shreg_if.slave
//          in : en, mode[2:0], d[WIDTH-1:0], sin, start
//          out: q, qn (=~q), sout (=q[0]), busy (state==SHIFT), done (pulse)
// WIDTH legal range is 2..32.
module d_en_shreg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic        clk,
  input  logic        rst,
  d_en_shreg_if.slave bus
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_SET  = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_q,     w_q_nx;
  logic [CW-1:0]    r_cnt,   w_cnt_nx;
  logic             r_done,  w_done_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= RESET_VAL;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_q     <= w_q_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_cnt_nx   = r_cnt;
    // done is a pure pulse: cleared every edge, even when en=0
    w_done_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // start bypasses en and outranks mode
        if (bus.start) begin
          w_q_nx     = bus.d;
          w_cnt_nx   = '0;
          w_state_nx = SHIFT;
        end else if (bus.en) begin
          case (bus.mode)
            M_LOAD:  w_q_nx = bus.d;
            M_SHL:   w_q_nx = {r_q[WIDTH-2:0], bus.sin};
            M_SHR:   w_q_nx = {bus.sin, r_q[WIDTH-1:1]};
            M_ROL:   w_q_nx = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            M_ROR:   w_q_nx = {r_q[0], r_q[WIDTH-1:1]};
            M_CLR:   w_q_nx = '0;
            M_SET:   w_q_nx = '1;
            default: w_q_nx = r_q;
          endcase
        end
      end
      SHIFT: begin
        // mode/start ignored here; en=0 stalls without losing bits
        if (bus.en) begin
          w_q_nx   = {bus.sin, r_q[WIDTH-1:1]};
          w_cnt_nx = r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.q    = r_q;
  assign bus.qn   = ~r_q;
  assign bus.sout = r_q[0];
  assign bus.busy = (r_state == SHIFT);
  assign bus.done = r_done;

endmodule

// File: tb/tb_d_en_shreg.sv
module tb_d_en_shreg;
  localparam int unsigned      W  = 8;
  localparam logic [W-1:0]     RV = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  d_en_shreg_if #(.WIDTH(W)) bus();
  d_en_shreg #(.WIDTH(W), .RESET_VAL(RV)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string cur_tag = "init";

  // reference model state
  logic [W-1:0] m_q    = RV;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, tag, obs, expv);
    end
  endtask

  // drive one cycle, push model prediction, pop and compare after the edge
  task automatic step(input logic en, input logic [2:0] mode, input logic [W-1:0] dv,
                      input logic s, input logic st);
    exp_t         e;
    logic [W-1:0] eqn;
    bus.en = en; bus.mode = mode; bus.d = dv; bus.sin = s; bus.start = st;
    m_done = 1'b0;
    if (!m_busy) begin
      if (st) begin
        m_q = dv; m_cnt = 0; m_busy = 1'b1;
      end else if (en) begin
        case (mode)
          3'b001:  m_q = dv;
          3'b010:  m_q = {m_q[W-2:0], s};
          3'b011:  m_q = {s, m_q[W-1:1]};
          3'b100:  m_q = {m_q[W-2:0], m_q[W-1]};
          3'b101:  m_q = {m_q[0], m_q[W-1:1]};
          3'b110:  m_q = '0;
          3'b111:  m_q = '1;
          default: ;
        endcase
      end
    end else if (en) begin
      m_q = {s, m_q[W-1:1]};
      if (m_cnt == W - 1) begin m_busy = 1'b0; m_done = 1'b1; end
      m_cnt++;
    end
    sb.push_back('{q: m_q, busy: m_busy, done: m_done});
    @(posedge clk); #1;
    e   = sb.pop_front();
    eqn = ~e.q;
    chk("q",    bus.q,    e.q);
    chk("qn",   bus.qn,   eqn);
    chk("sout", bus.sout, e.q[0]);
    chk("busy", bus.busy, e.busy);
    chk("done", bus.done, e.done);
  endtask

  // async reset asserted between edges; outputs must react without a clock
  task automatic mid_reset();
    logic [W-1:0] rvn;
    rvn = ~RV;
    #2 rst = 1'b1;
    #1;
    chk("rst_q",    bus.q,    RV);
    chk("rst_qn",   bus.qn,   rvn);
    chk("rst_sout", bus.sout, RV[0]);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    m_q = RV; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    #1 rst = 1'b0;
  endtask

  // serialize dv with an optional en=0 window; gather sout on advancing cycles
  task automatic serialize(input logic [W-1:0] dv, input int stall_at, input int stall_len,
                           output logic [W-1:0] seq, output int busy_cnt, output int done_cnt);
    int   k;
    logic e;
    seq = '0; busy_cnt = 0; done_cnt = 0;
    step(1'b1, 3'b000, dv, 1'b0, 1'b1);
    seq[0] = bus.sout; k = 1;
    busy_cnt += int'(bus.busy);
    for (int i = 0; i < int'(W) + stall_len + 1; i++) begin
      e = !(i >= stall_at && i < stall_at + stall_len);
      step(e, 3'b000, dv, 1'b0, 1'b0);
      if (bus.busy && e && k < int'(W)) begin seq[k] = bus.sout; k++; end
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq;
    int           bc, dc, guard;
    logic         seen;

    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 3'b000; bus.d = '0; bus.sin = 1'b0; bus.start = 1'b0;
    #3;
    cur_tag = "reset";
    chk("q",    bus.q,    RV);
    chk("busy", bus.busy, 1'b0);
    chk("done", bus.done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    cur_tag = "modes";
    step(1'b1, 3'b001, 8'h96, 1'b0, 1'b0); chk("load", bus.q, 8'h96);
    step(1'b1, 3'b010, 8'h00, 1'b1, 1'b0); chk("shl",  bus.q, 8'h2D);
    step(1'b1, 3'b011, 8'h00, 1'b0, 1'b0); chk("shr",  bus.q, 8'h16);
    step(1'b1, 3'b100, 8'h00, 1'b0, 1'b0); chk("rol",  bus.q, 8'h2C);
    step(1'b1, 3'b101, 8'h00, 1'b0, 1'b0); chk("ror",  bus.q, 8'h16);
    step(1'b1, 3'b110, 8'h00, 1'b0, 1'b0); chk("clr",  bus.q, 8'h00);
    step(1'b1, 3'b111, 8'h00, 1'b0, 1'b0); chk("set",  bus.q, 8'hFF);
    step(1'b0, 3'b001, 8'h12, 1'b0, 1'b0); chk("en0",  bus.q, 8'hFF);

    cur_tag = "midrst";
    mid_reset();

    cur_tag = "ser";
    serialize(8'hB4, 100, 0, seq, bc, dc);
    chk("seq",   seq, 8'hB4);
    chk("nbusy", bc,  8);
    chk("ndone", dc,  1);
    chk("fin_q", bus.q, 8'h00);

    cur_tag = "stall";
    serialize(8'hB4, 3, 3, seq, bc, dc);
    chk("seq",   seq, 8'hB4);
    chk("nbusy", bc,  11);
    chk("ndone", dc,  1);

    cur_tag = "busy_ign";
    step(1'b1, 3'b000, 8'h3C, 1'b0, 1'b1);
    step(1'b1, 3'b110, 8'hFF, 1'b0, 1'b1); chk("q1", bus.q, 8'h1E);
    step(1'b1, 3'b110, 8'hFF, 1'b0, 1'b1); chk("q2", bus.q, 8'h0F);
    for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    chk("q6", bus.q, 8'h00);
    chk("b6", bus.busy, 1'b1);
    seen = 1'b0; guard = 0;
    while (!seen && guard < 12) begin
      step(1'b1, 3'b000, 8'h81, 1'b0, 1'b1);
      seen = bus.done;
      guard++;
    end
    chk("done_seen",  seen, 1'b1);
    chk("done_busy",  bus.busy, 1'b0);
    step(1'b1, 3'b000, 8'h81, 1'b0, 1'b1);
    chk("reld_busy", bus.busy, 1'b1);
    chk("reld_q",    bus.q,    8'h81);
    chk("reld_done", bus.done, 1'b0);
    for (int i = 0; i < int'(W) + 1; i++) step(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    chk("reld_idle", bus.busy, 1'b0);

    cur_tag = "abort";
    step(1'b1, 3'b000, 8'hB4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    mid_reset();
    step(1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    chk("no_done", bus.done, 1'b0);
    serialize(8'h5A, 100, 0, seq, bc, dc);
    chk("seq",   seq, 8'h5A);
    chk("nbusy", bc,  8);
    chk("ndone", dc,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
